sobel_line_buffer: RTL and testbench

- Upstream feeder for sobel_top.
- Takes one raster-order pixel stream of 64-bit words (8 pixels per word) from a PCIe stream channel.
- Keeps the two previous image lines in on-chip storage and presents three column-aligned line streams to sobel_top's line1/line2/line3 valid/ack inputs.
- Lets the host send each image line once instead of three times over separate channels.

---
 rtl/sobel_pkg.sv | 9 +
 rtl/sobel_lb_ram.sv | 27 ++
 rtl/sobel_line_buffer.sv | 113 +++++++++++
 tb/tb_sobel_line_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared state encoding and width defaults for the Sobel front end
package sobel_pkg;
  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } lb_state_e;
  localparam int DEF_DATA_WIDTH  = 64;
  localparam int PIXELS_PER_WORD = 8;
endpackage

// File: rtl/sobel_lb_ram.sv
// sobel_lb_ram: one image line of storage, single port, async read, sync write
//   i_clk   clock
//   i_we    write enable
//   i_addr  word address (read and write)
//   i_wdata write word
//   o_rdata word at i_addr, combinational
module sobel_lb_ram
  import sobel_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_W     = 6
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  // Sized to the full address space so every address is in range; only the
  // first DEPTH entries are ever addressed because the column counter wraps.
  localparam int SLOTS = (1 << ADDR_W) > DEPTH ? (1 << ADDR_W) : DEPTH;
  logic [DATA_WIDTH-1:0] mem_q [SLOTS];
  always_ff @(posedge i_clk)
    if (i_we) mem_q[i_addr] <= i_wdata;
  assign o_rdata = mem_q[i_addr];
endmodule

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: turns one raster pixel-word stream into three column-aligned line streams
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_frame_start             restarts row/column counting, drops pending outputs
//   i_data_valid/i_data       input word, held until o_data_ack pulses
//   o_data_ack                one-cycle accept pulse
//   o_lineN_data_valid/_data  N=1: row r-2, N=2: row r-1, N=3: row r
//   i_lineN_data_ack          consumer accept per line, any order
// Build option SOBEL_LB_BORDER_REPLICATE_EN: rows 0 and 1 also produce
// outputs by replicating the top border.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int LINE_WORDS = 64,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COL_W      = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_start,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_data_ack,
  output logic                  o_line1_data_valid,
  output logic [DATA_WIDTH-1:0] o_line1_data,
  input  logic                  i_line1_data_ack,
  output logic                  o_line2_data_valid,
  output logic [DATA_WIDTH-1:0] o_line2_data,
  input  logic                  i_line2_data_ack,
  output logic                  o_line3_data_valid,
  output logic [DATA_WIDTH-1:0] o_line3_data,
  input  logic                  i_line3_data_ack
);
  lb_state_e state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic ack_q, ack_d;
  logic [2:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
  logic [DATA_WIDTH-1:0] old_rd, prev_rd, l1_src, l2_src;
  logic pending, acc, wrap, emit;
  // pending is simply "any output still owed"; it clears the cycle the last
  // valid drops, which lets the next accept happen in that same cycle.
  assign pending = |vld_q;
  assign acc = i_data_valid & ~ack_q & ~pending & ~i_frame_start;
  assign wrap = col_q == COL_W'(LINE_WORDS - 1);
`ifdef SOBEL_LB_BORDER_REPLICATE_EN
  assign emit = acc;
  assign l2_src = row_q == 2'd0 ? i_data : prev_rd;
  assign l1_src = state_q == STREAM ? old_rd : l2_src;
`else
  assign emit = acc & (state_q == STREAM);
  assign l2_src = prev_rd;
  assign l1_src = old_rd;
`endif
  // On every accept the column shifts one line down: prev -> old, input -> prev.
  sobel_lb_ram #(.DEPTH(LINE_WORDS), .DATA_WIDTH(DATA_WIDTH), .ADDR_W(COL_W)) u_mem_old (
    .i_clk  (i_clk),
    .i_we   (acc),
    .i_addr (col_q),
    .i_wdata(prev_rd),
    .o_rdata(old_rd)
  );
  sobel_lb_ram #(.DEPTH(LINE_WORDS), .DATA_WIDTH(DATA_WIDTH), .ADDR_W(COL_W)) u_mem_prev (
    .i_clk  (i_clk),
    .i_we   (acc),
    .i_addr (col_q),
    .i_wdata(i_data),
    .o_rdata(prev_rd)
  );
  always_comb begin
    ack_d = acc;
    col_d = acc ? (wrap ? '0 : col_q + 1'b1) : col_q;
    row_d = acc && wrap && row_q != 2'd2 ? row_q + 1'b1 : row_q;
    state_d = row_d == 2'd2 ? STREAM : state_q;
    vld_d = emit ? 3'b111 : vld_q & ~{i_line3_data_ack, i_line2_data_ack, i_line1_data_ack};
    l1_d = emit ? l1_src : l1_q;
    l2_d = emit ? l2_src : l2_q;
    l3_d = emit ? i_data : l3_q;
    if (i_frame_start) begin
      state_d = FILL;
      col_d = '0;
      row_d = '0;
      vld_d = '0;
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q <= FILL;
      col_q <= '0;
      row_q <= '0;
      ack_q <= 1'b0;
      vld_q <= '0;
      l1_q <= '0;
      l2_q <= '0;
      l3_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      ack_q <= ack_d;
      vld_q <= vld_d;
      l1_q <= l1_d;
      l2_q <= l2_d;
      l3_q <= l3_d;
    end
  assign o_data_ack = ack_q;
  assign o_line1_data_valid = vld_q[0];
  assign o_line2_data_valid = vld_q[1];
  assign o_line3_data_valid = vld_q[2];
  assign o_line1_data = l1_q;
  assign o_line2_data = l2_q;
  assign o_line3_data = l3_q;
endmodule

// File: tb/tb_sobel_line_buffer.sv
// tb_sobel_line_buffer: directed/randomized self-checking bench for sobel_line_buffer
module tb_sobel_line_buffer;
  localparam int LW = 4;
  localparam int DW = 64;
`ifdef SOBEL_LB_BORDER_REPLICATE_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, fs = 1'b0, dv = 1'b0, dack;
  logic [DW-1:0] din = '0;
  logic [2:0] v;
  logic [2:0] ack = '0;
  logic [2:0][DW-1:0] ld;
  int n_chk = 0, n_fail = 0, n_acc = 0, triples = 0, mrow = 0, mcol = 0, dmax = 0;
  logic [DW-1:0] img [64][LW];
  logic [DW-1:0] q_in [$];
  logic [DW-1:0] exp_d [3];
  bit live [3], acked [3];
  int age [3], dly [3], fix [3];
  bit prev_low = 1'b1, spur = 1'b0;
  sobel_line_buffer #(.LINE_WORDS(LW), .DATA_WIDTH(DW), .COL_W(2)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_frame_start     (fs),
    .i_data_valid      (dv),
    .i_data            (din),
    .o_data_ack        (dack),
    .o_line1_data_valid(v[0]),
    .o_line1_data      (ld[0]),
    .i_line1_data_ack  (ack[0]),
    .o_line2_data_valid(v[1]),
    .o_line2_data      (ld[1]),
    .i_line2_data_ack  (ack[1]),
    .o_line3_data_valid(v[2]),
    .o_line3_data      (ld[2]),
    .i_line3_data_ack  (ack[2])
  );
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  function automatic int exp_trip(input int rows);
    return BR ? rows * LW : (rows - 2) * LW;
  endfunction
  task automatic present();
    dv = q_in.size() > 0;
    din = q_in.size() > 0 ? q_in[0] : '0;
  endtask
  task automatic load_rows(input int rows, input bit rnd);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < LW; c++)
        q_in.push_back(rnd ? {$urandom, $urandom} : DW'(16 * r + c));
    present();
  endtask
  task automatic refill(input int total);
    while (q_in.size() > 1) void'(q_in.pop_back());
    while (q_in.size() < total) q_in.push_back({$urandom, $urandom});
    present();
  endtask
  // one clock of producer/consumer activity, checked against the image model
  task automatic tick();
    logic [DW-1:0] w;
    logic [DW-1:0] t [3];
    @(negedge clk);
    if (dack) begin
      chk("ack_after_idle", DW'(prev_low), DW'(1));
      w = q_in.pop_front();
      img[mrow][mcol] = w;
      t[2] = w;
      if (mrow == 0) begin
        t[1] = w;
        t[0] = w;
      end else if (mrow == 1) begin
        t[1] = img[0][mcol];
        t[0] = img[0][mcol];
      end else begin
        t[1] = img[mrow-1][mcol];
        t[0] = img[mrow-2][mcol];
      end
      if (mrow >= 2 || BR) begin
        for (int n = 0; n < 3; n++) begin
          chk("valid_on_accept", DW'(v[n]), DW'(1));
          chk("line_data", ld[n], t[n]);
          live[n] = 1'b1;
          acked[n] = 1'b0;
          age[n] = 0;
          exp_d[n] = t[n];
          dly[n] = fix[n] >= 0 ? fix[n] : int'($urandom_range(dmax, 0));
        end
        triples++;
      end else
        chk("fill_silent", DW'(v), DW'(0));
      n_acc++;
      mcol++;
      if (mcol == LW) begin
        mcol = 0;
        mrow++;
      end
      present();
    end else
      for (int n = 0; n < 3; n++)
        if (acked[n]) begin
          chk("drop_after_ack", DW'(v[n]), DW'(0));
          live[n] = 1'b0;
          acked[n] = 1'b0;
        end else if (live[n]) begin
          chk("hold_valid", DW'(v[n]), DW'(1));
          chk("hold_data", ld[n], exp_d[n]);
        end else
          chk("idle_valid", DW'(v[n]), DW'(0));
    prev_low = v == 3'b000;
    for (int n = 0; n < 3; n++) begin
      if (live[n] && !acked[n] && age[n] == dly[n]) begin
        ack[n] = 1'b1;
        acked[n] = 1'b1;
      end else
        ack[n] = !live[n] && spur && ($urandom_range(3, 0) == 0);
      if (live[n]) age[n]++;
    end
  endtask
  task automatic run_acc(input int target);
    int c = 0;
    while (n_acc < target && c < 2000) begin
      tick();
      c++;
    end
    chk("accept_timeout", DW'(n_acc >= target), DW'(1));
  endtask
  task automatic drain();
    int c = 0;
    while ((q_in.size() > 0 || live[0] || live[1] || live[2]) && c < 4000) begin
      tick();
      c++;
    end
    chk("drain_timeout", DW'(q_in.size() == 0 && !live[0] && !live[1] && !live[2]), DW'(1));
  endtask
  task automatic restart(input bit use_rst);
    if (use_rst) rst = 1'b1;
    else fs = 1'b1;
    ack = '0;
    @(negedge clk);
    rst = 1'b0;
    fs = 1'b0;
    chk("restart_ack", DW'(dack), DW'(0));
    chk("restart_valid", DW'(v), DW'(0));
    for (int n = 0; n < 3; n++) begin
      live[n] = 1'b0;
      acked[n] = 1'b0;
    end
    mrow = 0;
    mcol = 0;
    prev_low = 1'b1;
    triples = 0;
  endtask
  initial begin
    fix = '{-1, -1, -1};
    repeat (2) @(negedge clk);
    chk("reset_ack", DW'(dack), DW'(0));
    chk("reset_valid", DW'(v), DW'(0));
    chk("reset_l1", ld[0], DW'(0));
    chk("reset_l2", ld[1], DW'(0));
    chk("reset_l3", ld[2], DW'(0));
    rst = 1'b0;
    fix = '{0, 0, 0};
    load_rows(3, 1'b0);
    drain();
    chk("t1_triples", DW'(triples), DW'(exp_trip(3)));
    restart(1'b0);
    fix = '{3, 5, 0};
    load_rows(3, 1'b0);
    drain();
    chk("t2_triples", DW'(triples), DW'(exp_trip(3)));
    restart(1'b0);
    fix = '{-1, -1, -1};
    dmax = 3;
    spur = 1'b1;
    load_rows(5, 1'b1);
    drain();
    chk("t3_triples", DW'(triples), DW'(exp_trip(5)));
    restart(1'b0);
    spur = 1'b0;
    fix = '{6, 6, 6};
    load_rows(4, 1'b1);
    run_acc(n_acc + 14);
    restart(1'b0);
    fix = '{-1, -1, -1};
    refill(12);
    drain();
    chk("t4_triples", DW'(triples), DW'(exp_trip(3)));
    restart(1'b0);
    fix = '{0, 0, 0};
    load_rows(3, 1'b1);
    run_acc(n_acc + 9);
    tick();
    restart(1'b0);
    refill(12);
    drain();
    chk("t4b_triples", DW'(triples), DW'(exp_trip(3)));
    restart(1'b0);
    fix = '{-1, -1, -1};
    spur = 1'b1;
    load_rows(4, 1'b1);
    run_acc(n_acc + 10);
    restart(1'b1);
    refill(12);
    drain();
    chk("t5_triples", DW'(triples), DW'(exp_trip(3)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
